// File: rtl/dshift_unit.sv
// Two-stage valid/ready shifter: logical, arithmetic and rotate on one word {a} or a double word {a,b}.
// Define DSHIFT_OVERFLOW_EN to build in arithmetic-left overflow detection; otherwise overflow is tied low.
module dshift_unit #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CNT_W-1:0] count,
    input  logic [1:0]       op,
    input  logic             dbl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic             overflow
);
    localparam int DW = 2 * WIDTH;
    localparam logic [1:0] OP_ARI = 2'b01;
    localparam logic [1:0] OP_ROT = 2'b10;

    logic             s1_vld_q;
    logic [DW-1:0]    s1_opnd_q;
    logic [1:0]       s1_op_q;
    logic             s1_dbl_q;
    logic             s1_right_q;
    logic [CNT_W-1:0] s1_mag_q;
    logic             out_valid_q;
    logic             ovf_q;
    logic [WIDTH-1:0] out_hi_q;
    logic [WIDTH-1:0] out_lo_q;

    logic             s2_adv;
    logic             s1_load;
    logic [DW-1:0]    opnd_d;
    logic [CNT_W-1:0] mag_d;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_vld_q || s2_adv;
    assign s1_load  = in_valid && in_ready;

    // Single-word operands sit in the upper half so one datapath serves both widths.
    assign opnd_d = dbl ? {a, b} : {a, {WIDTH{1'b0}}};
    // Unsigned magnitude keeps -2^(CNT_W-1) as a positive 2^(CNT_W-1).
    assign mag_d  = count[CNT_W-1] ? (~count + CNT_W'(1)) : count;

    logic [DW-1:0]    shl, shr, sar, res, rot_d;
    logic [WIDTH-1:0] a_w, rot_s;
    logic [31:0]      mag32, rs, rd, ls, ld;
    logic             ovf_d;

    always_comb begin
        mag32 = 32'(s1_mag_q);
        shl   = s1_opnd_q << s1_mag_q;
        shr   = s1_opnd_q >> s1_mag_q;
        sar   = DW'($signed(s1_opnd_q) >>> s1_mag_q);
        rs    = mag32 % 32'(WIDTH);
        rd    = mag32 % 32'(DW);
        // A right rotate by r is a left rotate by (width - r).
        ls    = (!s1_right_q || rs == 32'd0) ? rs : 32'(WIDTH) - rs;
        ld    = (!s1_right_q || rd == 32'd0) ? rd : 32'(DW) - rd;
        a_w   = s1_opnd_q[DW-1 -: WIDTH];
        rot_s = (a_w << ls) | (a_w >> (32'(WIDTH) - ls));
        rot_d = (s1_opnd_q << ld) | (s1_opnd_q >> (32'(DW) - ld));
        case (s1_op_q)
            OP_ARI:  res = s1_right_q ? sar : {s1_opnd_q[DW-1], shl[DW-2:0]};
            OP_ROT:  res = s1_dbl_q ? rot_d : {rot_s, {WIDTH{1'b0}}};
            default: res = s1_right_q ? shr : shl;
        endcase
    end

`ifdef DSHIFT_OVERFLOW_EN
    logic [31:0]   mc;
    logic [DW-1:0] back;

    // Overflow when the top (mc+1) operand bits are not all equal, mc clamped to width-1.
    always_comb begin
        mc = s1_dbl_q ? 32'(DW - 1) : 32'(WIDTH - 1);
        if (mag32 < mc) mc = mag32;
        back  = DW'($signed(s1_opnd_q << mc) >>> mc);
        ovf_d = (s1_op_q == OP_ARI) && !s1_right_q && (back != s1_opnd_q);
    end
`else
    assign ovf_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q    <= 1'b0;
            s1_opnd_q   <= '0;
            s1_op_q     <= '0;
            s1_dbl_q    <= 1'b0;
            s1_right_q  <= 1'b0;
            s1_mag_q    <= '0;
            out_valid_q <= 1'b0;
            out_hi_q    <= '0;
            out_lo_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_vld_q   <= 1'b1;
                s1_opnd_q  <= opnd_d;
                s1_op_q    <= op;
                s1_dbl_q   <= dbl;
                s1_right_q <= count[CNT_W-1];
                s1_mag_q   <= mag_d;
            end else if (s2_adv) begin
                s1_vld_q <= 1'b0;
            end
            if (s2_adv) begin
                out_valid_q <= s1_vld_q;
                if (s1_vld_q) begin
                    out_hi_q <= res[DW-1 -: WIDTH];
                    out_lo_q <= s1_dbl_q ? res[WIDTH-1:0] : '0;
                    ovf_q    <= ovf_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_hi    = out_hi_q;
    assign out_lo    = out_lo_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_dshift_unit.sv
// Bench for dshift_unit: bit-level reference model, per-cycle monitor, directed vectors and random traffic.
module tb_dshift_unit;
    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] a;
    logic [35:0] b;
    logic [8:0]  count;
    logic [1:0]  op;
    logic        dbl;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_hi;
    logic [35:0] out_lo;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int ecnt = 0;
    int acc_cnt = 0;
    int out_cnt = 0;

    typedef struct {
        logic [35:0] hi;
        logic [35:0] lo;
        logic        ov;
        int          ea;
    } exp_t;
    exp_t q[$];

`ifdef DSHIFT_OVERFLOW_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    dshift_unit #(.WIDTH(36), .CNT_W(9)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .count(count), .op(op), .dbl(dbl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hi(out_hi), .out_lo(out_lo), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0o want=%0o t=%0t", nm, act, exp, $time);
        end
    endtask

    // Bit-by-bit evaluation of the shift rules; position 0 is the least significant bit.
    function automatic void model(input logic [35:0] ma, input logic [35:0] mb, input int c,
                                  input logic [1:0] mop, input logic mdbl,
                                  output logic [35:0] eh, output logic [35:0] el, output logic eo);
        logic [71:0] v;
        logic [71:0] r;
        int w, m, rr;
        w  = mdbl ? 72 : 36;
        v  = mdbl ? {ma, mb} : {36'd0, ma};
        r  = '0;
        eo = 1'b0;
        m  = (c < 0) ? -c : c;
        rr = ((c % w) + w) % w;
        for (int p = 0; p < w; p++) begin
            case (mop)
                2'b01: begin
                    if (c < 0) r[p] = (p + m < w) ? v[p + m] : v[w - 1];
                    else if (p == w - 1) r[p] = v[w - 1];
                    else r[p] = (p - m >= 0) ? v[p - m] : 1'b0;
                end
                2'b10: r[p] = v[(p - rr + w) % w];
                default: begin
                    if (c < 0) r[p] = (p + m < w) ? v[p + m] : 1'b0;
                    else r[p] = (p - m >= 0) ? v[p - m] : 1'b0;
                end
            endcase
        end
        if (mop == 2'b01 && c > 0)
            for (int i = 0; i < w - 1; i++)
                if (i + m > w - 2 && v[i] != v[w - 1]) eo = 1'b1;
        eo = eo & OVF_ON;
        eh = mdbl ? r[71:36] : r[35:0];
        el = mdbl ? r[35:0] : 36'd0;
    endfunction

    always @(negedge clk) begin : mon
        logic exp_ov, exp_ir, mo;
        logic [35:0] mh, ml;
        if (!reset_n) begin
            q.delete();
            chk("rst out_valid", 72'(out_valid), 72'd0);
            chk("rst in_ready", 72'(in_ready), 72'd1);
            chk("rst out_hi", 72'(out_hi), 72'd0);
            chk("rst out_lo", 72'(out_lo), 72'd0);
            chk("rst overflow", 72'(overflow), 72'd0);
        end else begin
            exp_ov = (q.size() > 0) && (q[0].ea + 1 <= ecnt);
            chk("out_valid", 72'(out_valid), 72'(exp_ov));
            if (exp_ov && out_valid) begin
                chk("out_hi", 72'(out_hi), 72'(q[0].hi));
                chk("out_lo", 72'(out_lo), 72'(q[0].lo));
                chk("overflow", 72'(overflow), 72'(q[0].ov));
            end
            exp_ir = !exp_ov || out_ready || (q.size() < 2);
            chk("in_ready", 72'(in_ready), 72'(exp_ir));
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                out_cnt++;
            end
            if (in_valid && in_ready) begin
                model(a, b, int'($signed(count)), op, dbl, mh, ml, mo);
                q.push_back('{hi: mh, lo: ml, ov: mo, ea: ecnt + 1});
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic vec(input string nm, input logic [35:0] va, input logic [35:0] vb, input int c,
                       input logic [1:0] vop, input logic vdbl,
                       input logic [35:0] xh, input logic [35:0] xl, input logic xo);
        logic [35:0] mh, ml;
        logic mo;
        model(va, vb, c, vop, vdbl, mh, ml, mo);
        chk({nm, " model hi"}, 72'(mh), 72'(xh));
        chk({nm, " model lo"}, 72'(ml), 72'(xl));
        chk({nm, " model ovf"}, 72'(mo), 72'(xo));
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1; a = va; b = vb; count = 9'(c); op = vop; dbl = vdbl;
        tick();
        in_valid = 1'b0;
        tick();
        chk({nm, " dut valid"}, 72'(out_valid), 72'd1);
        chk({nm, " dut hi"}, 72'(out_hi), 72'(xh));
        chk({nm, " dut lo"}, 72'(out_lo), 72'(xl));
        chk({nm, " dut ovf"}, 72'(overflow), 72'(xo));
        tick();
    endtask

    task automatic rand_req();
        int ctab[12] = '{0, 1, -1, 35, -35, 36, -36, 71, -71, 72, -256, 255};
        int c;
        case ($urandom_range(0, 3))
            0: a = $urandom_range(0, 1) ? 36'($urandom_range(0, 255)) : ~36'($urandom_range(0, 255));
            1: a = $urandom_range(0, 1) ? 36'o777777777777 : 36'o400000000000;
            default: a = 36'({$urandom(), $urandom()});
        endcase
        b   = 36'({$urandom(), $urandom()});
        c   = $urandom_range(0, 1) ? ctab[$urandom_range(0, 11)] : int'($urandom_range(0, 511)) - 256;
        count = 9'(c);
        op  = 2'($urandom_range(0, 3));
        dbl = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int acc0, out0;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; count = '0; op = '0; dbl = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        vec("lsl1", 36'o400000000001, 36'd0, 1, 2'b00, 1'b0, 36'o000000000002, 36'd0, 1'b0);
        vec("asr3", 36'o400000000000, 36'd0, -3, 2'b01, 1'b0, 36'o740000000000, 36'd0, 1'b0);
        vec("asr256", 36'o400000000000, 36'd0, -256, 2'b01, 1'b0, 36'o777777777777, 36'd0, 1'b0);
        vec("rotr1", 36'd0, 36'd1, -1, 2'b10, 1'b1, 36'o400000000000, 36'd0, 1'b0);
        vec("rot73", 36'd0, 36'd1, 73, 2'b10, 1'b1, 36'd0, 36'd2, 1'b0);
        vec("asl_ovf", 36'o200000000000, 36'd0, 1, 2'b01, 1'b0, 36'd0, 36'd0, OVF_ON);
        vec("cnt0", 36'o123456701234, 36'o765432107654, 0, 2'b01, 1'b1,
            36'o123456701234, 36'o765432107654, 1'b0);
        vec("rot_neg256", 36'o000000000017, 36'd0, -256, 2'b10, 1'b0, 36'o740000000000, 36'd0, 1'b0);
        vec("rsv_neg256", 36'o777777777777, 36'o777777777777, -256, 2'b11, 1'b1, 36'd0, 36'd0, 1'b0);

        // Backpressure: only two requests fit while the output is stalled.
        out_ready = 1'b0;
        tick();
        acc0 = acc_cnt;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            rand_req();
            tick();
        end
        chk("bp accepted", 72'(acc_cnt - acc0), 72'd2);
        chk("bp in_ready", 72'(in_ready), 72'd0);
        out0 = out_cnt;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("bp drained", 72'(out_cnt - out0), 72'd3);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            rand_req();
            tick();
        end
        in_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst out_valid", 72'(out_valid), 72'd0);
        chk("midrst in_ready", 72'(in_ready), 72'd1);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        out0 = out_cnt;
        repeat (5) tick();
        chk("midrst no stale", 72'(out_cnt - out0), 72'd0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                in_valid = 1'b0;
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_req();
            tick();
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("final drained", 72'(q.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
